// File: rtl/snn_layer_tm.sv
// Time-multiplexed leaky integrate-and-fire layer: NIN spike inputs, NOUT neurons,
// one weight accumulated per cycle, with leak, threshold, refractory period and saturation.
module snn_layer_tm #(
    parameter int NIN    = 4,
    parameter int NOUT   = 2,
    parameter int WW     = 16,
    parameter int VW     = 20,
    parameter int REFRAC = 2,
    localparam int AW    = WW + $clog2(NIN) + 1,
    localparam int ADW   = (NIN * NOUT > 1) ? $clog2(NIN * NOUT) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 step_valid,
    output logic                 step_ready,
    input  logic [NIN-1:0]       in_spikes,
    input  logic                 w_we,
    input  logic [ADW-1:0]       w_addr,
    input  logic signed [WW-1:0] w_data,
    input  logic signed [VW-1:0] threshold,
    input  logic [3:0]           leak_shift,
    output logic                 out_valid,
    output logic [NOUT-1:0]      out_spikes
);
    localparam int NW = NIN * NOUT;
    localparam int IW = (NIN > 1) ? $clog2(NIN) : 1;
    localparam int JW = (NOUT > 1) ? $clog2(NOUT) : 1;
    localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam int SW = VW + 2;
    localparam logic signed [SW-1:0] VMAX = $signed({3'b000, {(VW-1){1'b1}}});
    localparam logic signed [SW-1:0] VMIN = $signed({3'b111, {(VW-1){1'b0}}});

    typedef enum logic [1:0] {IDLE, ACCUM, UPDATE, DONE} state_e;

    state_e               state_q, state_d;
    logic [IW-1:0]        i_q, i_d;
    logic [JW-1:0]        j_q, j_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [NIN-1:0]       spk_in_q, spk_in_d;
    logic signed [VW-1:0] thr_q, thr_d;
    logic [3:0]           ls_q, ls_d;
    logic [NOUT-1:0]      spk_q, spk_d;
    logic [NOUT-1:0]      out_spk_q, out_spk_d;
    logic signed [WW-1:0] w_q [NW];
    logic signed [VW-1:0] v_q [NOUT];
    logic signed [VW-1:0] v_d [NOUT];
    logic [RW-1:0]        refr_q [NOUT];
    logic [RW-1:0]        refr_d [NOUT];

    function automatic logic signed [VW-1:0] sat_vw(input logic signed [SW-1:0] x);
        if (x > VMAX) return VMAX[VW-1:0];
        if (x < VMIN) return VMIN[VW-1:0];
        return x[VW-1:0];
    endfunction

    // A shift of zero means no leak rather than leaking the whole potential.
    function automatic logic signed [VW-1:0] leak_of(input logic signed [VW-1:0] v,
                                                     input logic [3:0] sh);
        logic signed [VW-1:0] r;
        if (sh == 4'd0) r = '0;
        else            r = v >>> sh;
        return r;
    endfunction

    logic [ADW-1:0]       rd_addr;
    logic signed [WW-1:0] w_sel;
    logic signed [AW-1:0] w_ext;
    logic signed [SW-1:0] v_sum;
    logic signed [VW-1:0] v_new;
    logic                 fire;

    assign rd_addr = ADW'(i_q) * ADW'(NOUT) + ADW'(j_q);
    assign w_sel   = w_q[rd_addr];
    assign w_ext   = $signed({{(AW-WW){w_sel[WW-1]}}, w_sel});
    assign v_sum   = SW'(v_q[j_q]) - SW'(leak_of(v_q[j_q], ls_q)) + SW'(acc_q);
    assign v_new   = sat_vw(v_sum);
    assign fire    = (v_new >= thr_q);

    assign step_ready = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_spikes = out_spk_q;

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        acc_d     = acc_q;
        spk_in_d  = spk_in_q;
        thr_d     = thr_q;
        ls_d      = ls_q;
        spk_d     = spk_q;
        out_spk_d = out_spk_q;
        v_d       = v_q;
        refr_d    = refr_q;
        case (state_q)
            IDLE: begin
                if (step_valid) begin
                    spk_in_d = in_spikes;
                    thr_d    = threshold;
                    ls_d     = leak_shift;
                    i_d      = '0;
                    j_d      = '0;
                    acc_d    = '0;
                    spk_d    = '0;
                    state_d  = ACCUM;
                end
            end
            ACCUM: begin
                if (spk_in_q[i_q]) acc_d = acc_q + w_ext;
                if (i_q == IW'(NIN - 1)) state_d = UPDATE;
                else                     i_d = i_q + IW'(1);
            end
            UPDATE: begin
                if (refr_q[j_q] != '0) begin
                    v_d[j_q]    = '0;
                    refr_d[j_q] = refr_q[j_q] - RW'(1);
                    spk_d[j_q]  = 1'b0;
                end else if (fire) begin
                    v_d[j_q]    = '0;
                    refr_d[j_q] = RW'(REFRAC);
                    spk_d[j_q]  = 1'b1;
                end else begin
                    v_d[j_q]    = v_new;
                end
                i_d   = '0;
                acc_d = '0;
                if (j_q == JW'(NOUT - 1)) begin
                    out_spk_d = spk_d;
                    state_d   = DONE;
                end else begin
                    j_d     = j_q + JW'(1);
                    state_d = ACCUM;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            i_q       <= '0;
            j_q       <= '0;
            spk_q     <= '0;
            out_spk_q <= '0;
            for (int n = 0; n < NOUT; n++) begin
                v_q[n]    <= '0;
                refr_q[n] <= '0;
            end
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            spk_q     <= spk_d;
            out_spk_q <= out_spk_d;
            v_q       <= v_d;
            refr_q    <= refr_d;
        end
    end

    // Step operands are only meaningful while a step is in flight, so they carry no reset.
    always_ff @(posedge clk) begin
        acc_q    <= acc_d;
        spk_in_q <= spk_in_d;
        thr_q    <= thr_d;
        ls_q     <= ls_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < NW; n++) w_q[n] <= '0;
        end else if (w_we && (int'(w_addr) < NW)) begin
            w_q[w_addr] <= w_data;
        end
    end
endmodule
